// File: rtl/rv32imf_pkg.sv
// Shared core package for the RV32IMF pipeline.
// Provides the operand width, the divider iteration count, the divide
// operation encoding and the helper that applies the final sign correction
// to a divider result.
package rv32imf_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;

  // op[0] set means unsigned, op[1] set means remainder.
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_e;

  // Selects the quotient or the remainder for the requested op and
  // restores its sign. Both magnitudes come from an unsigned divide of the
  // operand magnitudes, so the signed ops only need a conditional negate.
  // Negating 0x80000000 yields 0x80000000, which is exactly the required
  // overflow answer for the most-negative / -1 case.
  function automatic logic [XLEN-1:0] div_sign_fix(
    input div_op_e         op,
    input logic [XLEN-1:0] quo_mag,
    input logic [XLEN-1:0] rem_mag,
    input logic            neg_quo,
    input logic            neg_rem
  );
    logic [XLEN-1:0] res;
    res = quo_mag;
    case (op)
      DIV_OP_DIV:  res = neg_quo ? (~quo_mag + 1'b1) : quo_mag;
      DIV_OP_DIVU: res = quo_mag;
      DIV_OP_REM:  res = neg_rem ? (~rem_mag + 1'b1) : rem_mag;
      DIV_OP_REMU: res = rem_mag;
      default:     res = quo_mag;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/int_div_unit.sv
// Iterative 32-bit integer divider (DIV, DIVU, REM, REMU).
// One restoring radix-2 step per cycle on operand magnitudes, followed by a
// sign correction when the result is registered.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset_n    - asynchronous active-low reset
//   start      - request a divide this cycle (accepted in IDLE or DONE)
//   op         - div_op_e encoding: DIV=0, DIVU=1, REM=2, REMU=3
//   dividend   - rs1 value
//   divisor    - rs2 value
//   flush      - abandon any in-flight or requested divide
//   busy       - unit occupied (high in CALC)
//   valid      - one-cycle result strobe (high in DONE)
//   result     - quotient or remainder, held until the next valid
//   state_dbg  - current FSM state for observation
//
// Handshake: a request is taken on a rising edge where start=1, flush=0
// and the unit is not in CALC; start is ignored otherwise and need not be
// held. valid is a single-cycle strobe with no back-pressure; result stays
// stable from that strobe until the next one.
module int_div_unit #(
  parameter int XLEN = rv32imf_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);
  import rv32imf_pkg::*;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [4:0] CNT_INIT = 5'(DIV_ITERS - 1);

  logic [1:0]      state_q;
  logic [4:0]      cnt_q;
  div_op_e         op_q;
  logic [XLEN-1:0] a_q;      // dividend magnitude, shifted out MSB first
  logic [XLEN-1:0] b_q;      // divisor magnitude
  logic [XLEN:0]   rem_q;    // 33-bit partial remainder
  logic [XLEN-1:0] quo_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            busy_q;
  logic            valid_q;
  logic [XLEN-1:0] result_q;

  // Request decode
  logic            accept;
  logic            div_by_zero;
  logic            is_signed;
  logic            is_rem;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] dbz_result;

  always_comb begin
    accept      = start && !flush && (state_q != ST_CALC);
    div_by_zero = (divisor == '0);
    is_signed   = !op[0];
    is_rem      = op[1];
    abs_a       = (is_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
    abs_b       = (is_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;
    dbz_result  = is_rem ? dividend : '1;
  end

  // One restoring step: shift the next dividend bit into the remainder,
  // trial-subtract the divisor and keep the difference only when it does
  // not borrow. The extra top bit of diff is the borrow.
  logic [XLEN:0]   rem_shift;
  logic [XLEN+1:0] diff;
  logic            borrow;
  logic [XLEN:0]   rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] final_result;

  always_comb begin
    rem_shift    = {rem_q[XLEN-1:0], a_q[XLEN-1]};
    diff         = {1'b0, rem_shift} - {2'b00, b_q};
    borrow       = diff[XLEN+1];
    rem_next     = borrow ? rem_shift : diff[XLEN:0];
    quo_next     = {quo_q[XLEN-2:0], ~borrow};
    final_result = div_sign_fix(op_q, quo_next, rem_next[XLEN-1:0],
                                neg_quo_q, neg_rem_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= DIV_OP_DIV;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      // Flush beats a simultaneous start; result keeps its last value.
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (accept) begin
      op_q      <= div_op_e'(op);
      a_q       <= abs_a;
      b_q       <= abs_b;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_quo_q <= (op == DIV_OP_DIV) && (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_rem_q <= (op == DIV_OP_REM) && dividend[XLEN-1];
      if (div_by_zero) begin
        // No iterations needed: the answer is known now.
        state_q  <= ST_DONE;
        cnt_q    <= '0;
        busy_q   <= 1'b0;
        valid_q  <= 1'b1;
        result_q <= dbz_result;
      end else begin
        state_q <= ST_CALC;
        cnt_q   <= CNT_INIT;
        busy_q  <= 1'b1;
        valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_CALC: begin
          a_q   <= {a_q[XLEN-2:0], 1'b0};
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            // Last step: register the corrected answer as we enter DONE.
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            result_q <= final_result;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_int_div_unit.sv
// Self-checking bench for int_div_unit: directed corner cases, randomized
// operations against an arithmetic reference model, back-to-back issue,
// flush and mid-operation reset.
module tb_int_div_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int n_chk;
  int n_pass;

  int_div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .valid     (valid),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Plain 64-bit arithmetic; truncating division and a remainder that
  // follows the dividend's sign, as RISC-V requires.
  function automatic logic [31:0] ref_result(input logic [1:0] o,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    if (b == 32'd0) return (o[1]) ? a : 32'hFFFF_FFFF;
    case (o)
      2'd0:    r = sa / sb;
      2'd1:    r = ua / ub;
      2'd2:    r = sa % sb;
      default: r = ua % ub;
    endcase
    return r[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
  endtask

  // Clocks until valid (bounded); lat = -1 on timeout. Counts cycles
  // before valid in which busy was low.
  task automatic wait_valid(output int lat, output int busy_low);
    lat      = -1;
    busy_low = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (valid) begin
        lat = i;
        break;
      end
      if (!busy) busy_low++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; flush = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
    #3;
    n_chk++;
    if ({busy, valid, result} !== 34'd0)
      $display("FAIL reset_hold busy=%0b valid=%0b result=%h want 0/0/0", busy, valid, result);
    else n_pass++;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0)
      $display("FAIL reset_release busy=%0b valid=%0b result=%h want 0/0/0", busy, valid, result);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [1:0]  ops[8]  = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2};
    logic [31:0] as_[8]  = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'd5,
                             32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] bs[8]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd2};
    logic [31:0] exp_r[8] = '{32'hFFFF_FFF2, 32'd2, 32'hFFFF_FFFF, 32'd5,
                              32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int lat, bl, exp_lat;
    for (int i = 0; i < 8; i++) begin
      exp_lat = (bs[i] == 32'd0) ? 1 : 33;
      launch(ops[i], as_[i], bs[i]);
      wait_valid(lat, bl);
      n_chk++;
      if (lat != exp_lat)
        $display("FAIL dir_latency[%0d] got=%0d want=%0d", i, lat, exp_lat);
      else n_pass++;
      n_chk++;
      if (result !== exp_r[i])
        $display("FAIL dir_result[%0d] got=%h want=%h", i, result, exp_r[i]);
      else n_pass++;
      n_chk++;
      if (busy !== 1'b0 || bl != 0)
        $display("FAIL dir_busy[%0d] busy_in_done=%0b low_cycles=%0d want 0/0", i, busy, bl);
      else n_pass++;
      tick();
      n_chk++;
      if (valid !== 1'b0 || result !== exp_r[i])
        $display("FAIL dir_hold[%0d] valid=%0b result=%h want 0/%h", i, valid, result, exp_r[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, e;
    logic [1:0]  o;
    int lat, bl, exp_lat, sel;
    logic [31:0] exp_q[$];
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom();
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: b = 32'(($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF);
        4: b = $urandom_range(1, 15);
        default: b = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      exp_q.push_back(ref_result(o, a, b));
      exp_lat = (b == 32'd0) ? 1 : 33;
      launch(o, a, b);
      wait_valid(lat, bl);
      e = exp_q.pop_front();
      n_chk++;
      if (lat != exp_lat || result !== e)
        $display("FAIL rand[%0d] op=%0d a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                 i, o, a, b, result, lat, e, exp_lat);
      else n_pass++;
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_back_to_back();
    int lat, bl;
    logic [31:0] e1, e2;
    e1 = ref_result(2'd0, 32'd1000, 32'd7);
    e2 = ref_result(2'd2, 32'hFFFF_FC18, 32'd7);
    launch(2'd0, 32'd1000, 32'd7);
    wait_valid(lat, bl);
    n_chk++;
    if (lat != 33 || result !== e1 || bl != 0)
      $display("FAIL b2b_first lat=%0d result=%h busy_low=%0d want 33/%h/0", lat, result, bl, e1);
    else n_pass++;
    // Second request issued in the DONE cycle of the first.
    launch(2'd2, 32'hFFFF_FC18, 32'd7);
    wait_valid(lat, bl);
    n_chk++;
    if (lat != 33 || result !== e2 || bl != 0)
      $display("FAIL b2b_second lat=%0d result=%h busy_low=%0d want 33/%h/0", lat, result, bl, e2);
    else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    int vcount, lat, bl;
    logic [31:0] prev, e;
    prev = result;
    launch(2'd1, 32'd123456, 32'd77);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) start = 1'b0;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || valid !== 1'b0)
      $display("FAIL flush_now busy=%0b valid=%0b want 0/0", busy, valid);
    else n_pass++;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid || busy) vcount++;
    end
    n_chk++;
    if (vcount != 0 || result !== prev)
      $display("FAIL flush_after active_cycles=%0d result=%h want 0/%h", vcount, result, prev);
    else n_pass++;
    // Flush together with start: start must be dropped.
    launch(2'd0, 32'd9, 32'd3);
    flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || valid !== 1'b0)
      $display("FAIL flush_vs_start busy=%0b valid=%0b want 0/0", busy, valid);
    else n_pass++;
    e = ref_result(2'd0, 32'hFFFF_FF9C, 32'd9);
    launch(2'd0, 32'hFFFF_FF9C, 32'd9);
    wait_valid(lat, bl);
    n_chk++;
    if (lat != 33 || result !== e)
      $display("FAIL flush_then_op lat=%0d result=%h want 33/%h", lat, result, e);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_calc();
    int act;
    launch(2'd0, 32'd77777, 32'd5);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0)
      $display("FAIL reset_mid busy=%0b valid=%0b result=%h want 0/0/0", busy, valid, result);
    else n_pass++;
    tick();
    reset_n = 1'b1;
    act = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid || busy) act++;
    end
    n_chk++;
    if (act != 0 || result !== 32'd0)
      $display("FAIL reset_after active_cycles=%0d result=%h want 0/0", act, result);
    else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
